csc_wg_to_gem_roll_search: RTL



---
 rtl/csc_wg_to_gem_roll_search.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/csc_wg_to_gem_roll_search.sv
// CSC key wiregroup -> GEM roll search.
// Scans the eight GEM roll wiregroup windows [low, high] of the selected
// chamber parity one roll per clock. It reports the set of rolls whose window
// contains the key wiregroup, plus the lowest and highest matching roll.
//
// Handshake: start is sampled only while idle. Sampling it latches wg and
// even and raises busy. Eight clocks later the results update, done pulses
// for one cycle and busy drops. A start seen while busy is dropped, not queued.
// Window tables are rewritten through wen/w_sel/w_adr/w_data at any time.
// A scan reads the value held before a same-edge write.
module csc_wg_to_gem_roll_search #(
    parameter int NROLL = 8,
    parameter int WGW   = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wen,
    input  logic [1:0]       w_sel,
    input  logic [2:0]       w_adr,
    input  logic [WGW-1:0]   w_data,
    input  logic             start,
    input  logic             even,
    input  logic [WGW-1:0]   wg,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [2:0]       roll_first,
    output logic [2:0]       roll_last,
    output logic [NROLL-1:0] roll_mask
);

    localparam logic [2:0] LAST_IDX = 3'(NROLL - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Window tables hold their configuration values from power-up; reset leaves them alone.
    logic [WGW-1:0] odd_low   [NROLL] = '{7'd37, 7'd31, 7'd27, 7'd22, 7'd19, 7'd15, 7'd11, 7'd8};
    logic [WGW-1:0] odd_high  [NROLL] = '{7'd47, 7'd44, 7'd38, 7'd33, 7'd28, 7'd23, 7'd19, 7'd15};
    logic [WGW-1:0] even_low  [NROLL] = '{7'd37, 7'd31, 7'd27, 7'd22, 7'd17, 7'd13, 7'd10, 7'd6};
    logic [WGW-1:0] even_high [NROLL] = '{7'd47, 7'd44, 7'd38, 7'd32, 7'd27, 7'd22, 7'd17, 7'd14};

    state_t           state, state_next;
    logic [2:0]       index;
    logic [WGW-1:0]   wg_lat;
    logic             even_lat;
    logic [NROLL-1:0] acc_mask, acc_mask_next;
    logic [2:0]       acc_first, acc_first_next;
    logic [2:0]       acc_last, acc_last_next;
    logic [WGW-1:0]   rd_low, rd_high;
    logic             hit;

    // Table write port; w_sel[1] picks parity, w_sel[0] picks the high bound.
    always_ff @(posedge clock) begin
        if (wen) begin
            case (w_sel)
                2'b00:   odd_low[w_adr]   <= w_data;
                2'b01:   odd_high[w_adr]  <= w_data;
                2'b10:   even_low[w_adr]  <= w_data;
                default: even_high[w_adr] <= w_data;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM next state: idle until start, then exactly eight scan cycles.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = SCAN;
            SCAN: if (index == LAST_IDX) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == SCAN);

    // Evaluate the current roll window against the latched wiregroup and fold it into the accumulators.
    always_comb begin
        rd_low         = even_lat ? even_low[index]  : odd_low[index];
        rd_high        = even_lat ? even_high[index] : odd_high[index];
        hit            = (wg_lat >= rd_low) && (wg_lat <= rd_high);
        acc_mask_next  = acc_mask;
        acc_first_next = acc_first;
        acc_last_next  = acc_last;
        if (hit) begin
            acc_mask_next[index] = 1'b1;
            acc_last_next        = index;
            if (acc_mask == '0) acc_first_next = index;
        end
    end

    // Scan datapath: latch the request, step the index, publish results on the last roll.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            index      <= '0;
            wg_lat     <= '0;
            even_lat   <= 1'b0;
            acc_mask   <= '0;
            acc_first  <= '0;
            acc_last   <= '0;
            done       <= 1'b0;
            found      <= 1'b0;
            roll_first <= '0;
            roll_last  <= '0;
            roll_mask  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        wg_lat    <= wg;
                        even_lat  <= even;
                        acc_mask  <= '0;
                        acc_first <= '0;
                        acc_last  <= '0;
                        index     <= '0;
                    end
                end
                SCAN: begin
                    acc_mask  <= acc_mask_next;
                    acc_first <= acc_first_next;
                    acc_last  <= acc_last_next;
                    index     <= index + 3'd1;
                    if (index == LAST_IDX) begin
                        roll_mask  <= acc_mask_next;
                        roll_first <= acc_first_next;
                        roll_last  <= acc_last_next;
                        found      <= |acc_mask_next;
                        done       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
